uart_tx_fifo_core: RTL and testbench

//  Next-generation UART transmitter. Replaces the fixed-table baud generator with a

---
 rtl/uart_tx_fifo_core.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_core.sv
// UART transmitter with a word FIFO, programmable bit period, 5-8 data bits, parity and 1/2 stop bits.
// Latency: a word pushed into an empty FIFO while idle drives the start bit one cycle after the push edge.
// Backpressure: DataReady follows the registered FIFO full flag; a full FIFO refuses pushes even on a pop edge.
module uart_tx_fifo_core #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic [DIV_W-1:0]   BaudDiv,
    input  logic [1:0]         DataLength,
    input  logic [1:0]         ParityType,
    input  logic               StopBits,
    input  logic [7:0]         DataIn,
    input  logic               DataValid,
    output logic               DataReady,
    output logic               TxOut,
    output logic               ActiveFlag,
    output logic               DoneFlag,
    output logic [FIFO_AW:0]   FifoLevel
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [2:0]       lastBit;
        logic             parEn;
        logic             parOdd;
        logic             twoStop;
    } frameCfg_t;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);

    txState_t         state, stateNext;
    frameCfg_t        cfg, cfgNext, newCfg;
    logic [7:0]       dataReg, dataNext, headDat;
    logic [DIV_W-1:0] baudCnt, cntNext, reloadCnt;
    logic [2:0]       bitIdx, bitNext;
    logic             stopIdx, stopNext;
    logic             txNext, doneNext, load, fifoEmpty, cntZero, parityBit;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (Clock),
        .rstN    (ResetN),
        .pushVld (DataValid),
        .pushDat (DataIn),
        .pushRdy (DataReady),
        .popEn   (load),
        .popDat  (headDat),
        .empty   (fifoEmpty),
        .level   (FifoLevel)
    );

    // Frame settings sampled from the live inputs at the moment a word is popped.
    always_comb begin
        newCfg.div     = (BaudDiv < DIV_TWO) ? DIV_TWO : BaudDiv;
        newCfg.lastBit = {1'b1, DataLength};
        newCfg.parEn   = ^ParityType;
        newCfg.parOdd  = (ParityType == 2'b01);
        newCfg.twoStop = StopBits;
    end

    assign cntZero   = (baudCnt == '0);
    assign reloadCnt = cfg.div - DIV_ONE;
    assign parityBit = (^dataReg) ^ cfg.parOdd;

    always_comb begin
        stateNext = state;
        cfgNext   = cfg;
        dataNext  = dataReg;
        cntNext   = cntZero ? '0 : baudCnt - DIV_ONE;
        bitNext   = bitIdx;
        stopNext  = stopIdx;
        txNext    = TxOut;
        doneNext  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: load = !fifoEmpty;
            START: if (cntZero) begin
                stateNext = DATA;
                bitNext   = 3'd0;
                txNext    = dataReg[0];
                cntNext   = reloadCnt;
            end
            DATA: if (cntZero) begin
                cntNext = reloadCnt;
                if (bitIdx == cfg.lastBit) begin
                    if (cfg.parEn) begin
                        stateNext = PARITY;
                        txNext    = parityBit;
                    end else begin
                        stateNext = STOP;
                        stopNext  = 1'b0;
                        txNext    = 1'b1;
                    end
                end else begin
                    bitNext = bitIdx + 3'd1;
                    txNext  = dataReg[bitNext];
                end
            end
            PARITY: if (cntZero) begin
                stateNext = STOP;
                stopNext  = 1'b0;
                txNext    = 1'b1;
                cntNext   = reloadCnt;
            end
            STOP: if (cntZero) begin
                if (stopIdx == cfg.twoStop) begin
                    doneNext = 1'b1;
                    if (!fifoEmpty) begin
                        load = 1'b1;
                    end else begin
                        stateNext = IDLE;
                        txNext    = 1'b1;
                    end
                end else begin
                    stopNext = 1'b1;
                    cntNext  = reloadCnt;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Pop path shared by idle start-up and stop-to-start chaining.
        if (load) begin
            stateNext = START;
            cfgNext   = newCfg;
            dataNext  = headDat & (8'hFF >> ~DataLength);
            cntNext   = newCfg.div - DIV_ONE;
            txNext    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state      <= IDLE;
            cfg        <= '0;
            dataReg    <= '0;
            baudCnt    <= '0;
            bitIdx     <= '0;
            stopIdx    <= 1'b0;
            TxOut      <= 1'b1;
            ActiveFlag <= 1'b0;
            DoneFlag   <= 1'b0;
        end else begin
            state      <= stateNext;
            cfg        <= cfgNext;
            dataReg    <= dataNext;
            baudCnt    <= cntNext;
            bitIdx     <= bitNext;
            stopIdx    <= stopNext;
            TxOut      <= txNext;
            ActiveFlag <= (stateNext != IDLE);
            DoneFlag   <= doneNext;
        end
    end
endmodule

// Generic synchronous FIFO with an occupancy count and a registered full flag.
// Latency: a pushed word is at the head one cycle after its push edge.
// Backpressure: pushRdy is low while full; a pop on the same edge does not admit a push.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             pushVld,
    input  logic [WIDTH-1:0] pushDat,
    output logic             pushRdy,
    input  logic             popEn,
    output logic [WIDTH-1:0] popDat,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      levelNext;
    logic             full, doPush, doPop;

    assign doPush  = pushVld && !full;
    assign doPop   = popEn && !empty;
    assign pushRdy = !full;
    assign empty   = (level == '0);
    assign popDat  = mem[rdPtr];

    always_comb begin
        levelNext = level;
        if (doPush && !doPop) levelNext = level + LVL_ONE;
        else if (doPop && !doPush) levelNext = level - LVL_ONE;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            full  <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
            level <= levelNext;
            full  <= (levelNext == LVL_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushDat;
    end
endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Bench for uart_tx_fifo_core: a queue-based line model checked every cycle plus literal frame checks.
module tb_uart_tx_fifo_core;
    logic        Clock, ResetN;
    logic [15:0] BaudDiv;
    logic [1:0]  DataLength, ParityType;
    logic        StopBits;
    logic [7:0]  DataIn;
    logic        DataValid;
    logic        DataReady, TxOut, ActiveFlag, DoneFlag;
    logic [2:0]  FifoLevel;

    int compared = 0;
    int mismatched = 0;

    uart_tx_fifo_core #(.DIV_W(16), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .BaudDiv    (BaudDiv),
        .DataLength (DataLength),
        .ParityType (ParityType),
        .StopBits   (StopBits),
        .DataIn     (DataIn),
        .DataValid  (DataValid),
        .DataReady  (DataReady),
        .TxOut      (TxOut),
        .ActiveFlag (ActiveFlag),
        .DoneFlag   (DoneFlag),
        .FifoLevel  (FifoLevel)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired before the expected event (t=%0t)", nm, $time);
    endtask

    // Line model: per-cycle expected TxOut samples of the frame in flight, plus queued words.
    bit         lineQ[$];
    logic [7:0] wordQ[$];
    bit         expDone, mAccepted, wasBusy, roomFree;
    logic [7:0] headWord;

    function automatic void buildFrame(input logic [7:0] w);
        bit seq[$];
        int nData = int'(DataLength) + 5;
        int div = (BaudDiv < 16'd2) ? 2 : int'(BaudDiv);
        int ones = 0;
        seq.push_back(1'b0);
        for (int i = 0; i < nData; i++) begin
            seq.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (ParityType == 2'b10) seq.push_back(ones % 2 == 1);
        else if (ParityType == 2'b01) seq.push_back(ones % 2 == 0);
        seq.push_back(1'b1);
        if (StopBits) seq.push_back(1'b1);
        foreach (seq[k])
            for (int c = 0; c < div; c++) lineQ.push_back(seq[k]);
    endfunction

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            lineQ.delete();
            wordQ.delete();
            expDone   = 1'b0;
            mAccepted = 1'b0;
        end else begin
            wasBusy  = (lineQ.size() != 0);
            roomFree = (wordQ.size() < 4);
            if (wasBusy) void'(lineQ.pop_front());
            expDone = wasBusy && (lineQ.size() == 0);
            if (lineQ.size() == 0 && wordQ.size() != 0) begin
                headWord = wordQ.pop_front();
                buildFrame(headWord);
            end
            mAccepted = DataValid && roomFree;
            if (mAccepted) wordQ.push_back(DataIn);
        end
    end

    int actRun = 0, lastRun = 0, doneCnt = 0;

    always @(negedge Clock) begin
        if (ResetN) begin
            chk("TxOut", int'(TxOut), (lineQ.size() != 0) ? int'(lineQ[0]) : 1);
            chk("ActiveFlag", int'(ActiveFlag), int'(lineQ.size() != 0));
            chk("DoneFlag", int'(DoneFlag), int'(expDone));
            chk("FifoLevel", int'(FifoLevel), wordQ.size());
            chk("DataReady", int'(DataReady), int'(wordQ.size() < 4));
            if (DoneFlag) doneCnt++;
            if (ActiveFlag) actRun++;
            else begin
                if (actRun != 0) lastRun = actRun;
                actRun = 0;
            end
        end else begin
            actRun = 0;
        end
    end

    task automatic pushWord(input logic [7:0] w);
        int n = 0;
        DataIn    = w;
        DataValid = 1'b1;
        do begin
            @(negedge Clock);
            n++;
        end while (!mAccepted && n < 200);
        if (!mAccepted) fail($sformatf("push_0x%02h", w));
    endtask

    task automatic waitIdle(input string nm);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while ((ActiveFlag || wordQ.size() != 0) && n < 2000);
        if (ActiveFlag) fail(nm);
    endtask

    // seq[i] is the literal line level of bit i (start bit first); each bit spans div cycles.
    task automatic expectFrame(input string nm, input logic [15:0] seq, input int nBits, input int div);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (TxOut !== 1'b0 && n < 400);
        if (TxOut !== 1'b0) begin
            fail({nm, " start"});
            return;
        end
        for (int c = 0; c <= nBits * div; c++) begin
            if (c > 0) @(negedge Clock);
            if (c < nBits * div && (c % div == 0 || c % div == div - 1))
                chk($sformatf("%s bit%0d cyc%0d", nm, c / div, c), int'(TxOut), int'(seq[c / div]));
            if (c == nBits * div - 1) chk({nm, " done_early"}, int'(DoneFlag), 0);
            if (c == nBits * div) chk({nm, " done"}, int'(DoneFlag), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int doneBase;

    initial begin
        ResetN     = 1'b1;
        BaudDiv    = 16'd4;
        DataLength = 2'b11;
        ParityType = 2'b00;
        StopBits   = 1'b0;
        DataIn     = 8'h00;
        DataValid  = 1'b0;
        #3 ResetN  = 1'b0;
        #1;
        chk("rst TxOut", int'(TxOut), 1);
        chk("rst ActiveFlag", int'(ActiveFlag), 0);
        chk("rst DoneFlag", int'(DoneFlag), 0);
        chk("rst DataReady", int'(DataReady), 1);
        chk("rst FifoLevel", int'(FifoLevel), 0);
        @(negedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        repeat (3) @(negedge Clock);

        // T1: div 4, 8N1, 0xA5
        pushWord(8'hA5);
        DataValid = 1'b0;
        expectFrame("T1", 16'b11_0100_1010, 10, 4);
        waitIdle("T1 idle");

        // T2: div 3, 7 bits, even parity, 2 stop, 0x53
        BaudDiv = 16'd3; DataLength = 2'b10; ParityType = 2'b10; StopBits = 1'b1;
        pushWord(8'h53);
        DataValid = 1'b0;
        expectFrame("T2", 16'b110_1010_0110, 11, 3);
        waitIdle("T2 idle");

        // T3: odd parity, 5 bits
        BaudDiv = 16'd2; DataLength = 2'b00; ParityType = 2'b01; StopBits = 1'b0;
        pushWord(8'h1F);
        DataValid = 1'b0;
        expectFrame("T3a", 16'b1011_1110, 8, 2);
        waitIdle("T3a idle");
        pushWord(8'h1E);
        DataValid = 1'b0;
        expectFrame("T3b", 16'b1111_1100, 8, 2);
        waitIdle("T3b idle");

        // T4: six back-to-back words, 5N1 at div 2 (14 cycles per frame)
        ParityType = 2'b00;
        doneBase = doneCnt;
        pushWord(8'h01);
        pushWord(8'h02);
        pushWord(8'h03);
        pushWord(8'h04);
        pushWord(8'h05);
        chk("T4 level_full", int'(FifoLevel), 4);
        chk("T4 ready_low", int'(DataReady), 0);
        pushWord(8'h16);
        DataValid = 1'b0;
        waitIdle("T4 idle");
        @(negedge Clock);
        chk("T4 active_run", lastRun, 84);
        chk("T4 done_count", doneCnt - doneBase, 6);

        // T5: length change mid-frame applies to the next frame only
        DataLength = 2'b11;
        doneBase = doneCnt;
        pushWord(8'h3C);
        pushWord(8'hE6);
        DataValid = 1'b0;
        repeat (5) @(negedge Clock);
        DataLength = 2'b00;
        waitIdle("T5 idle");
        @(negedge Clock);
        chk("T5 active_run", lastRun, 34);
        chk("T5 done_count", doneCnt - doneBase, 2);

        // T6: asynchronous reset during data bit 3, then BaudDiv=1
        DataLength = 2'b11;
        BaudDiv = 16'd4;
        pushWord(8'hA5);
        pushWord(8'h11);
        DataValid = 1'b0;
        repeat (17) @(negedge Clock);
        chk("T6 pre_tx", int'(TxOut), 0);
        chk("T6 pre_level", int'(FifoLevel), 1);
        #2 ResetN = 1'b0;
        #1;
        chk("T6 rst TxOut", int'(TxOut), 1);
        chk("T6 rst ActiveFlag", int'(ActiveFlag), 0);
        chk("T6 rst FifoLevel", int'(FifoLevel), 0);
        chk("T6 rst DataReady", int'(DataReady), 1);
        @(negedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        repeat (8) @(negedge Clock);
        chk("T6 idle TxOut", int'(TxOut), 1);
        chk("T6 idle ActiveFlag", int'(ActiveFlag), 0);
        BaudDiv = 16'd1;
        pushWord(8'h0F);
        DataValid = 1'b0;
        expectFrame("T6 div1", 16'b10_0001_1110, 10, 2);
        waitIdle("T6 idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
